// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a valid/ack key handoff.
// Drives one row low at a time, samples the synchronised columns on each scan tick,
// and delivers one key code per debounced press.
module keypad_scan #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       key_ovf
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;

    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [1:0]       state, state_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       key_col, key_col_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;

    logic [3:0]       key_code_nxt;
    logic             key_valid_nxt;
    logic             key_held_nxt;
    logic             key_ovf_nxt;

    logic             single;
    logic [1:0]       col_idx;
    logic             accept;

    // Two-stage synchroniser for the asynchronous column inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Scan tick divider, wraps at CLK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Classify the column pattern: exactly one low column, and which one
    always_comb begin
        single  = 1'b0;
        col_idx = 2'd0;
        case (col_sync)
            4'b1110: begin single = 1'b1; col_idx = 2'd0; end
            4'b1101: begin single = 1'b1; col_idx = 2'd1; end
            4'b1011: begin single = 1'b1; col_idx = 2'd2; end
            4'b0111: begin single = 1'b1; col_idx = 2'd3; end
            default: begin single = 1'b0; col_idx = 2'd0; end
        endcase
    end

    assign cnt_inc  = cnt + CNT_W'(1);
    assign cnt_done = (cnt_inc == CNT_W'(DEBOUNCE_TICKS));

    // Next-state and output logic for the scan/debounce/press FSM and key handoff
    always_comb begin
        state_nxt     = state;
        row_idx_nxt   = row_idx;
        key_col_nxt   = key_col;
        cnt_nxt       = cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = key_valid;
        key_held_nxt  = key_held;
        key_ovf_nxt   = key_ovf;
        accept        = 1'b0;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        key_col_nxt = col_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = PRESSED;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && (col_idx == key_col)) begin
                        if (cnt_done) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = PRESSED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt     = '0;
                        row_idx_nxt = row_idx + 2'd1;
                        state_nxt   = SCAN;
                    end
                end
                PRESSED: begin
                    if (col_sync == 4'hF) begin
                        if (cnt_done) begin
                            key_held_nxt = 1'b0;
                            cnt_nxt      = '0;
                            row_idx_nxt  = row_idx + 2'd1;
                            state_nxt    = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            endcase
        end

        // A new key beats a simultaneous ack; an unacked key causes the new one to be dropped
        if (accept) begin
            key_held_nxt = 1'b1;
            if (!key_valid || key_ack) begin
                key_code_nxt  = {row_idx, col_idx};
                key_valid_nxt = 1'b1;
            end else begin
                key_ovf_nxt = 1'b1;
            end
        end else if (key_ack && key_valid) begin
            key_valid_nxt = 1'b0;
            key_ovf_nxt   = 1'b0;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_n     <= 4'b1110;
            key_col   <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            row_n     <= ~(4'b0001 << row_idx_nxt);
            key_col   <= key_col_nxt;
            cnt       <= cnt_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            key_ovf   <= key_ovf_nxt;
        end
    end

endmodule
